// File: rtl/keypad_scanner_if.sv
// Keypad-side and Hack-side signals of the matrix keypad scanner.
// The master side is the scanner; the slave side is the keypad/consumer.
interface keypad_scanner_if;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] kbd;
  logic        key_strobe;

  modport master (input col_in, output row_out, output kbd, output key_strobe);
  modport slave  (output col_in, input row_out, input kbd, input key_strobe);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes rows, samples synchronized columns once per
// row dwell, and publishes a single debounced key as a Hack keyboard code.
module keypad_scanner #(
  parameter int SCAN_DIV = 1024,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.master kp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE);
  localparam logic [4:0]    CAND_NONE  = 5'h10;

  function automatic logic [15:0] key_code(input logic [3:0] idx);
    logic [7:0] c;
    case (idx)
      4'd0:  c = 8'h31;
      4'd1:  c = 8'h32;
      4'd2:  c = 8'h33;
      4'd3:  c = 8'h41;
      4'd4:  c = 8'h34;
      4'd5:  c = 8'h35;
      4'd6:  c = 8'h36;
      4'd7:  c = 8'h42;
      4'd8:  c = 8'h37;
      4'd9:  c = 8'h38;
      4'd10: c = 8'h39;
      4'd11: c = 8'h43;
      4'd12: c = 8'h2A;
      4'd13: c = 8'h30;
      4'd14: c = 8'h23;
      default: c = 8'h44;
    endcase
    return {8'h00, c};
  endfunction

  // Returns {multiple_pressed, candidate}; candidate is CAND_NONE when nothing is pressed.
  function automatic logic [5:0] classify(input logic [15:0] raw);
    logic [4:0] cand;
    logic       multi;
    logic       seen;
    cand  = CAND_NONE;
    multi = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (raw[i]) begin
        if (seen) multi = 1'b1;
        else begin
          seen = 1'b1;
          cand = {1'b0, 4'(i)};
        end
      end
    end
    return {multi, cand};
  endfunction

  logic [3:0]    sync1_q, sync2_q;
  logic [DW-1:0] dwell_q;
  logic [1:0]    row_q;
  logic [15:0]   raw_q;
  logic          frame_q;
  logic [4:0]    last_cand_q, last_cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   kbd_q, kbd_d;
  logic          strobe_q, strobe_d;

  logic          dwell_wrap;
  logic          multi;
  logic [4:0]    cand;

  assign dwell_wrap = (dwell_q == DWELL_LAST);

  // Frame classification runs the clock after the row-3 sample lands in raw_q.
  always_comb begin
    {multi, cand} = classify(raw_q);
    last_cand_d   = last_cand_q;
    cnt_d         = cnt_q;
    kbd_d         = kbd_q;
    strobe_d      = 1'b0;
    if (frame_q && !multi) begin
      if (cand == last_cand_q) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else begin
        last_cand_d = cand;
        cnt_d       = CW'(1);
      end
      if (cnt_d == CNT_MAX) begin
        kbd_d    = last_cand_d[4] ? 16'h0000 : key_code(last_cand_d[3:0]);
        strobe_d = (kbd_d != 16'h0000) && (kbd_d != kbd_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 4'hF;
      sync2_q     <= 4'hF;
      dwell_q     <= '0;
      row_q       <= 2'd0;
      frame_q     <= 1'b0;
      last_cand_q <= CAND_NONE;
      cnt_q       <= '0;
      kbd_q       <= 16'h0000;
      strobe_q    <= 1'b0;
    end else begin
      sync1_q     <= kp.col_in;
      sync2_q     <= sync1_q;
      dwell_q     <= dwell_wrap ? '0 : dwell_q + 1'b1;
      if (dwell_wrap) row_q <= row_q + 1'b1;
      frame_q     <= dwell_wrap && (row_q == 2'd3);
      last_cand_q <= last_cand_d;
      cnt_q       <= cnt_d;
      kbd_q       <= kbd_d;
      strobe_q    <= strobe_d;
    end
  end

  // Raw key image; every row is rewritten before it is classified, so no reset needed.
  always_ff @(posedge clk) begin
    if (dwell_wrap) raw_q[{row_q, 2'b00} +: 4] <= ~sync2_q;
  end

  assign kp.row_out    = ~(4'b0001 << row_q);
  assign kp.kbd        = kbd_q;
  assign kp.key_strobe = strobe_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model plus a frame-level reference model.
module tb_keypad_scanner;
  localparam int SD    = 4;
  localparam int DB    = 3;
  localparam int FRAME = 4 * SD;
  localparam int NONE  = 16;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] press = 16'h0000;
  logic [3:0]  colv;

  keypad_scanner_if kp();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its column to its row while that row is driven low.
  always_comb begin
    colv = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!kp.row_out[r] && press[4*r+c]) colv[c] = 1'b0;
  end
  assign kp.col_in = colv;

  logic [7:0] codes [16] = '{8'h31, 8'h32, 8'h33, 8'h41, 8'h34, 8'h35, 8'h36, 8'h42,
                             8'h37, 8'h38, 8'h39, 8'h43, 8'h2A, 8'h30, 8'h23, 8'h44};

  int          errors, checks, nstb, nbad;
  int          t, last_cand, cnt;
  logic [15:0] p1, p2, rawm, exp_kbd, pend_code;
  logic        exp_stb;
  bit          pend;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    t = 0; p1 = '0; p2 = '0; rawm = '0;
    exp_kbd = '0; exp_stb = 1'b0; pend = 0; pend_code = '0;
    last_cand = NONE; cnt = 0;
  endtask

  function automatic logic [3:0] exp_row();
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << ((t / SD) % 4));
  endfunction

  task automatic frame_end();
    int n, idx;
    n = 0; idx = NONE;
    for (int i = 0; i < 16; i++)
      if (rawm[i]) begin
        n++;
        if (idx == NONE) idx = i;
      end
    if (n < 2) begin
      if (idx == last_cand) begin
        if (cnt < DB) cnt++;
      end else begin
        last_cand = idx;
        cnt = 1;
      end
      if (cnt == DB) begin
        pend = 1;
        pend_code = (last_cand == NONE) ? 16'h0000 : {8'h00, codes[last_cand]};
      end
    end
  endtask

  // One clock of the reference: the row sampled at the end of each dwell sees the
  // key state from two clocks earlier; outputs move one clock after each frame end.
  task automatic model_edge();
    int r;
    exp_stb = 1'b0;
    if (pend) begin
      if (pend_code != 16'h0000 && pend_code != exp_kbd) exp_stb = 1'b1;
      exp_kbd = pend_code;
      pend = 0;
    end
    t++;
    if (t % SD == 0) begin
      r = ((t - 1) / SD) % 4;
      rawm[4*r +: 4] = p2[4*r +: 4];
      if (r == 3) frame_end();
    end
    p2 = p1;
    p1 = press;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
    check("kbd", kp.kbd, exp_kbd);
    check("strobe", {15'h0, kp.key_strobe}, {15'h0, exp_stb});
    check("row_out", {12'h0, kp.row_out}, {12'h0, exp_row()});
    if (kp.key_strobe === 1'b1) nstb++;
    if (kp.kbd !== exp_kbd) nbad++;
  endtask

  task automatic wait_kbd(input string tag, input logic [15:0] want, input int limit, output int k);
    k = 0;
    while (kp.kbd !== want && k < limit) begin
      tick();
      k++;
    end
    check(tag, kp.kbd, want);
  endtask

  initial begin
    int k;
    logic [15:0] held;
    errors = 0; checks = 0; nstb = 0; nbad = 0;
    model_reset();

    // Reset held low.
    repeat (3) tick();
    check("rst_kbd", kp.kbd, 16'h0000);
    check("rst_row", {12'h0, kp.row_out}, 16'h000E);
    reset = 1'b1;

    // Idle scanning.
    nstb = 0;
    repeat (10 * FRAME) tick();
    check("idle_strobes", 16'(nstb), 16'd0);
    check("idle_kbd", kp.kbd, 16'h0000);

    // Press and hold '5'.
    repeat (3) tick();
    press[5] = 1'b1;
    nstb = 0;
    wait_kbd("p5_kbd", 16'h0035, (DB + 2) * FRAME, k);
    check("p5_strobes", 16'(nstb), 16'd1);
    nstb = 0;
    repeat (10 * FRAME) tick();
    check("p5_hold_strobes", 16'(nstb), 16'd0);
    check("p5_hold_kbd", kp.kbd, 16'h0035);

    // Release '5'.
    press = 16'h0000;
    nstb = 0;
    wait_kbd("rel5_kbd", 16'h0000, 4 * FRAME + 3 + 4, k);
    check("rel5_latency", 16'(k <= 4 * FRAME + 3), 16'd1);
    check("rel5_strobes", 16'(nstb), 16'd0);
    repeat (2 * FRAME) tick();

    // Bounce '#' then hold it.
    nstb = 0; nbad = 0;
    k = 0;
    for (int i = 0; i < 64; i++) begin
      if (i % 5 == 0) press[14] = ~press[14];
      tick();
      if (kp.kbd !== 16'h0000) k++;
    end
    check("bounce_kbd_zero", 16'(k), 16'd0);
    press[14] = 1'b1;
    wait_kbd("hash_kbd", 16'h0023, (DB + 2) * FRAME, k);
    check("hash_strobes", 16'(nstb), 16'd1);
    press = 16'h0000;
    wait_kbd("hash_rel", 16'h0000, (DB + 2) * FRAME, k);
    repeat (FRAME) tick();

    // '1' held, then 'D' added, then '1' released.
    press[0] = 1'b1;
    wait_kbd("one_kbd", 16'h0031, (DB + 2) * FRAME, k);
    press[15] = 1'b1;
    nstb = 0; k = 0;
    for (int i = 0; i < 8 * FRAME; i++) begin
      tick();
      if (kp.kbd !== 16'h0031) k++;
    end
    check("two_keys_hold", 16'(k), 16'd0);
    check("two_keys_strobes", 16'(nstb), 16'd0);
    press[0] = 1'b0;
    wait_kbd("d_kbd", 16'h0044, (DB + 2) * FRAME, k);
    check("d_strobes", 16'(nstb), 16'd1);
    press = 16'h0000;
    wait_kbd("d_rel", 16'h0000, (DB + 2) * FRAME, k);

    // Asynchronous reset while '0' is shown.
    press[13] = 1'b1;
    wait_kbd("zero_kbd", 16'h0030, (DB + 2) * FRAME, k);
    #2 reset = 1'b0;
    #1;
    check("async_rst_kbd", kp.kbd, 16'h0000);
    check("async_rst_row", {12'h0, kp.row_out}, 16'h000E);
    check("async_rst_stb", {15'h0, kp.key_strobe}, 16'h0000);
    model_reset();
    repeat (2) tick();
    reset = 1'b1;
    nstb = 0;
    wait_kbd("zero_again", 16'h0030, (DB + 2) * FRAME, k);
    check("zero_again_latency", 16'(k), 16'(3 * FRAME + 1));
    check("zero_again_strobes", 16'(nstb), 16'd1);

    // Random key activity: none, one key, or two keys, held for random spans.
    for (int n = 0; n < 40; n++) begin
      held = 16'h0000;
      case ($urandom_range(0, 3))
        0: held = 16'h0000;
        1, 2: held[$urandom_range(0, 15)] = 1'b1;
        default: begin
          held[$urandom_range(0, 15)] = 1'b1;
          held[$urandom_range(0, 15)] = 1'b1;
        end
      endcase
      press = held;
      repeat ($urandom_range(1, 6 * FRAME)) tick();
    end
    press = 16'h0000;
    repeat ((DB + 2) * FRAME) tick();
    check("final_kbd", kp.kbd, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
